lcd_init_seq: RTL



---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_init_seq_if.sv | 18 +
 rtl/lcd_init_rom.sv | 38 +++
 rtl/lcd_init_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: entry encoding, FSM state codes and helpers shared by
// the LCD init sequencer and its command ROM.
package lcd_pkg;

  localparam logic [1:0] ENT_CMD   = 2'b00;
  localparam logic [1:0] ENT_DATA  = 2'b01;
  localparam logic [1:0] ENT_DELAY = 2'b10;
  localparam logic [1:0] ENT_END   = 2'b11;

  localparam logic [2:0] RST_LOW  = 3'd0;
  localparam logic [2:0] RST_WAIT = 3'd1;
  localparam logic [2:0] FETCH    = 3'd2;
  localparam logic [2:0] SHIFT    = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;
  localparam logic [2:0] DELAY    = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] val;
  } ent_t;

  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_init_seq_if.sv
// lcd_init_seq_if: panel-side pins of the init sequencer
// (panel reset plus the 3-wire SPI link).
interface lcd_init_seq_if;
  logic lcd_reset;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;

  modport master (
    output lcd_reset, spi_cs_n,
    output spi_sclk, spi_mosi
  );

  modport slave (
    input lcd_reset, spi_cs_n,
    input spi_sclk, spi_mosi
  );
endinterface

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: synchronous command-list ROM, one entry per address.
// Maps onto block RAM; swap the list to bring up a different panel.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int ROM_DEPTH = 64,
  parameter bit USE_IMG = 1'b0,
  parameter logic [ROM_DEPTH*10-1:0] IMG = '0
) (
  input  logic clk,
  input  logic [$clog2(ROM_DEPTH)-1:0] addr,
  output ent_t q
);

  function automatic ent_t panel_ent(input int a);
    unique case (a)
      0:  return {ENT_CMD,   8'h01};
      1:  return {ENT_DELAY, 8'd120};
      2:  return {ENT_CMD,   8'h11};
      3:  return {ENT_DELAY, 8'd120};
      4:  return {ENT_CMD,   8'h36};
      5:  return {ENT_DATA,  8'h00};
      6:  return {ENT_CMD,   8'h3A};
      7:  return {ENT_DATA,  8'h66};
      8:  return {ENT_CMD,   8'hB0};
      9:  return {ENT_DATA,  8'h11};
      10: return {ENT_CMD,   8'h29};
      11: return {ENT_DELAY, 8'd20};
      default: return {ENT_END, 8'h00};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (USE_IMG) q <= IMG[int'(addr)*10 +: 10];
    else         q <= panel_ent(int'(addr));
  end

endmodule

// File: rtl/lcd_init_seq.sv
// lcd_init_seq: pulses panel reset, plays the command list over
// 9-bit 3-wire SPI, then releases the pixel timing generator.
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int RST_LOW_CYCLES  = 202000,
  parameter int RST_WAIT_CYCLES = 2424000,
  parameter int SPI_DIV         = 4,
  parameter int DELAY_UNIT      = 20200,
  parameter int ROM_DEPTH       = 64,
  parameter bit USE_IMG         = 1'b0,
  parameter logic [ROM_DEPTH*10-1:0] IMG = '0
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  lcd_init_seq_if.master pnl,
  output logic busy,
  output logic timing_en
);

  localparam int AW = $clog2(ROM_DEPTH);
  localparam int DW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int CMAX = lcd_max(
    lcd_max(RST_LOW_CYCLES, RST_WAIT_CYCLES),
    lcd_max(255 * DELAY_UNIT, SPI_DIV));
  localparam int CW = $clog2(CMAX + 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] dly;
  logic [DW-1:0] dcnt;
  logic [3:0]    bcnt;
  logic [7:0]    sh;
  logic [AW-1:0] addr;
  logic          fph;
  logic          lcd_rst;
  logic          cs_n;
  logic          sclk;
  logic          mosi;
  ent_t          q;

  lcd_init_rom #(
    .ROM_DEPTH(ROM_DEPTH),
    .USE_IMG(USE_IMG),
    .IMG(IMG)
  ) u_rom (
    .clk(clk),
    .addr(addr),
    .q(q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= RST_LOW;
      cnt     <= '0;
      dly     <= '0;
      dcnt    <= '0;
      bcnt    <= '0;
      sh      <= '0;
      addr    <= '0;
      fph     <= 1'b0;
      lcd_rst <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (restart) begin
      state   <= RST_LOW;
      cnt     <= '0;
      dly     <= '0;
      dcnt    <= '0;
      bcnt    <= '0;
      sh      <= '0;
      addr    <= '0;
      fph     <= 1'b0;
      lcd_rst <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      unique case (state)
        RST_LOW:
          if (cnt == CW'(RST_LOW_CYCLES - 1)) begin
            lcd_rst <= 1'b1;
            cnt     <= '0;
            state   <= RST_WAIT;
          end else cnt <= cnt + CW'(1);
        RST_WAIT:
          if (cnt == CW'(RST_WAIT_CYCLES - 1)) begin
            cnt   <= '0;
            addr  <= '0;
            fph   <= 1'b0;
            state <= FETCH;
          end else cnt <= cnt + CW'(1);
        FETCH: begin
          fph <= ~fph;
          // second cycle: ROM output now reflects addr
          if (fph) begin
            unique case (1'b1)
              q.typ == ENT_END: state <= DONE;
              q.typ == ENT_DELAY: begin
                dly   <= CW'(q.val) * CW'(DELAY_UNIT);
                cnt   <= '0;
                state <= DELAY;
              end
              default: begin
                sh    <= q.val;
                mosi  <= q.typ[0];
                cs_n  <= 1'b0;
                sclk  <= 1'b0;
                dcnt  <= '0;
                bcnt  <= '0;
                state <= SHIFT;
              end
            endcase
          end
        end
        SHIFT:
          if (dcnt == DW'(SPI_DIV - 1)) begin
            dcnt <= '0;
            if (!sclk) sclk <= 1'b1;
            else if (bcnt == 4'd8) begin
              sclk  <= 1'b0;
              cs_n  <= 1'b1;
              mosi  <= 1'b0;
              cnt   <= '0;
              state <= GAP;
            end else begin
              sclk <= 1'b0;
              bcnt <= bcnt + 4'd1;
              mosi <= sh[7];
              sh   <= {sh[6:0], 1'b0};
            end
          end else dcnt <= dcnt + DW'(1);
        GAP:
          if (cnt == CW'(SPI_DIV - 1)) begin
            cnt <= '0;
            fph <= 1'b0;
            if (&addr) state <= DONE;
            else begin
              addr  <= addr + AW'(1);
              state <= FETCH;
            end
          end else cnt <= cnt + CW'(1);
        DELAY:
          if ((dly == '0) || (cnt == dly - CW'(1))) begin
            cnt <= '0;
            fph <= 1'b0;
            if (&addr) state <= DONE;
            else begin
              addr  <= addr + AW'(1);
              state <= FETCH;
            end
          end else cnt <= cnt + CW'(1);
        DONE: ;
        default: state <= RST_LOW;
      endcase
    end
  end

  assign pnl.lcd_reset = lcd_rst;
  assign pnl.spi_cs_n  = cs_n;
  assign pnl.spi_sclk  = sclk;
  assign pnl.spi_mosi  = mosi;
  assign busy          = (state != DONE);
  assign timing_en     = (state == DONE);

endmodule
